// File: rtl/sar_pkg.sv
// Shared types and defaults for the successive-approximation search controller.
package sar_pkg;

  localparam int unsigned SAR_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SEARCH = 2'b01,
    DONE   = 2'b10
  } sar_state_t;

  // A well-behaved comparator reports exactly one of eq/lt/gt.
  function automatic logic rel_valid(input logic eq, input logic lt, input logic gt);
    return (eq & ~lt & ~gt) | (~eq & lt & ~gt) | (~eq & ~lt & gt);
  endfunction

endpackage

// File: rtl/sar_search.sv
// MSB-first successive-approximation search against an external magnitude
// comparator; recovers the comparator's hidden operand through compare-only access.
module sar_search
  import sar_pkg::*;
#(
  parameter int unsigned WIDTH = SAR_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             cmp_eq,
  input  logic             cmp_lt,
  input  logic             cmp_gt,
  output logic [WIDTH-1:0] guess,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             hit,
  output logic             err
);

  localparam int unsigned     KW   = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [KW-1:0]   KTOP = KW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  localparam logic [WIDTH-1:0] MSB = ONE << (WIDTH - 1);

  sar_state_t       state, state_nxt;
  logic [WIDTH-1:0] acc, acc_nxt, acc_upd, probe;
  logic [KW-1:0]    k, k_nxt;
  logic [WIDTH-1:0] guess_nxt, result_nxt;
  logic             busy_nxt, done_nxt, hit_nxt, err_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      acc    <= '0;
      k      <= KTOP;
      guess  <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      hit    <= 1'b0;
      err    <= 1'b0;
    end else begin
      state  <= state_nxt;
      acc    <= acc_nxt;
      k      <= k_nxt;
      guess  <= guess_nxt;
      busy   <= busy_nxt;
      done   <= done_nxt;
      result <= result_nxt;
      hit    <= hit_nxt;
      err    <= err_nxt;
    end
  end

  // gt keeps the trial bit (acc takes the guess); lt drops it (acc unchanged).
  always_comb begin
    acc_upd = cmp_gt ? guess : acc;
    probe   = acc_upd | (ONE << (k - KW'(1)));
  end

  always_comb begin
    state_nxt  = state;
    acc_nxt    = acc;
    k_nxt      = k;
    guess_nxt  = guess;
    busy_nxt   = busy;
    done_nxt   = 1'b0;
    result_nxt = result;
    hit_nxt    = hit;
    err_nxt    = err;

    unique case (state)
      IDLE: begin
        if (start) begin
          acc_nxt   = '0;
          k_nxt     = KTOP;
          guess_nxt = MSB;
          busy_nxt  = 1'b1;
          hit_nxt   = 1'b0;
          err_nxt   = 1'b0;
          state_nxt = SEARCH;
        end
      end

      SEARCH: begin
        if (!rel_valid(cmp_eq, cmp_lt, cmp_gt)) begin
          err_nxt    = 1'b1;
          result_nxt = acc;
          busy_nxt   = 1'b0;
          state_nxt  = DONE;
        end else if (cmp_eq) begin
          hit_nxt    = 1'b1;
          result_nxt = guess;
          busy_nxt   = 1'b0;
          state_nxt  = DONE;
        end else begin
          acc_nxt = acc_upd;
          if (k != '0) begin
            k_nxt     = k - KW'(1);
            guess_nxt = probe;
          end else begin
            result_nxt = acc_upd;
            hit_nxt    = 1'b0;
            busy_nxt   = 1'b0;
            state_nxt  = DONE;
          end
        end
      end

      DONE: begin
        done_nxt  = 1'b1;
        state_nxt = IDLE;
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_sar_search.sv
// Bench for sar_search paired with a behavioural 4-bit comparator and a
// result scoreboard popped on every done pulse.
module tb_sar_search;

  typedef struct packed {
    logic [3:0] res;
    logic       hit;
    logic       err;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n, start;
  logic [3:0] target;
  logic       inj;
  logic       cmp_eq, cmp_lt, cmp_gt;
  logic [3:0] guess, result;
  logic       busy, done, hit, err;

  int         n_vec = 0;
  int         n_mis = 0;
  int         n_push = 0;
  int         n_done = 0;
  logic       prev_done = 1'b0;
  exp_t       sb[$];
  logic [3:0] seen[$];

  always #5 clk = ~clk;

  // Comparator: x = target, y = guess; inj corrupts it to eq=lt=1.
  assign cmp_eq = inj | (target == guess);
  assign cmp_lt = inj | (target < guess);
  assign cmp_gt = ~inj & (target > guess);

  sar_search #(.WIDTH(4)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .cmp_eq (cmp_eq),
    .cmp_lt (cmp_lt),
    .cmp_gt (cmp_gt),
    .guess  (guess),
    .busy   (busy),
    .done   (done),
    .result (result),
    .hit    (hit),
    .err    (err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic push(input logic [3:0] r, input logic h, input logic e);
    exp_t x;
    x.res = r; x.hit = h; x.err = e;
    sb.push_back(x);
    n_push++;
  endtask

  always @(negedge clk) begin
    if (rst_n && done) begin
      exp_t e;
      n_done++;
      check("done_pulse", prev_done, 0);
      if (sb.size() == 0) check("done_unexpected", done, 0);
      else begin
        e = sb.pop_front();
        check("result", result, e.res);
        check("hit", hit, e.hit);
        check("err", err, e.err);
      end
    end
    prev_done = done;
  end

  // One search: pulse start, record guesses while busy, measure edges to done.
  task automatic run(input logic [3:0] t, input int inj_at, output int lat);
    seen.delete();
    lat = 0;
    @(negedge clk); target = t; start = 1'b1;
    @(negedge clk); start = 1'b0;
    check("acc_busy", busy, 1);
    check("acc_hit", hit, 0);
    check("acc_err", err, 0);
    while (!done && lat < 20) begin
      if (busy) seen.push_back(guess);
      inj = (lat == inj_at);
      @(negedge clk); lat++;
    end
    inj = 1'b0;
  endtask

  task automatic check_seq(input string tag, input logic [15:0] exp, input int n);
    check({tag, "_len"}, seen.size(), n);
    for (int i = 0; i < n && i < seen.size(); i++)
      check(tag, seen[i], exp[15-4*i -: 4]);
  endtask

  // Reference: MSB-first trial sequence and number of comparator cycles.
  task automatic model(input logic [3:0] t, output logic [15:0] seq, output int n);
    logic [3:0] a, g;
    a = '0; seq = '0; n = 0;
    for (int b = 3; b >= 0; b--) begin
      g = a | (4'd1 << b);
      seq[15-4*n -: 4] = g;
      n++;
      if (g == t) break;
      if (t > g) a = g;
    end
  endtask

  initial begin
    int         lat, w, n;
    logic [15:0] seq;
    rst_n = 1'b0; start = 1'b0; target = '0; inj = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_guess", guess, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_result", result, 0);
    check("rst_hit", hit, 0);
    check("rst_err", err, 0);
    rst_n = 1'b1;

    push(4'hB, 1, 0); run(4'hB, -1, lat);
    check("B_lat", lat, 5); check_seq("B_seq", 16'h8CAB, 4);

    push(4'h8, 1, 0); run(4'h8, -1, lat);
    check("8_lat", lat, 2); check_seq("8_seq", 16'h8000, 1);

    push(4'h0, 0, 0); run(4'h0, -1, lat);
    check("0_lat", lat, 5); check_seq("0_seq", 16'h8421, 4);

    push(4'hF, 1, 0); run(4'hF, -1, lat);
    check("F_lat", lat, 5); check_seq("F_seq", 16'h8CEF, 4);

    push(4'h8, 0, 1); run(4'hB, 1, lat);
    check("flt_lat", lat, 3); check_seq("flt_seq", 16'h8C00, 2);
    push(4'hB, 1, 0); run(4'hB, -1, lat);
    check("flt_next_lat", lat, 5);

    // start held for 10 edges: second search may only begin after IDLE returns
    push(4'h5, 1, 0); push(4'h5, 1, 0);
    @(negedge clk); target = 4'h5; start = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("held_busy", busy, (c <= 3 || c >= 6) ? 1 : 0);
      check("held_done", done, (c == 5) ? 1 : 0);
    end
    start = 1'b0;
    w = 0;
    while (!done && w < 10) begin @(negedge clk); w++; end
    check("held_done2", done, 1);

    // asynchronous reset during the third SEARCH cycle
    @(negedge clk); target = 4'hB; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("mid_guess", guess, 4'hA);
    rst_n = 1'b0;
    #1;
    check("arst_guess", guess, 0);
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_result", result, 0);
    check("arst_hit", hit, 0);
    check("arst_err", err, 0);
    #3 rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check("post_rst_done", done, 0);
      check("post_rst_busy", busy, 0);
    end
    push(4'h3, 1, 0); run(4'h3, -1, lat);
    check("3_lat", lat, 5); check_seq("3_seq", 16'h8423, 4);

    for (int t = 0; t < 16; t++) begin
      model(4'(t), seq, n);
      push(4'(t), (t != 0), 0);
      run(4'(t), -1, lat);
      check("sweep_lat", lat, n + 1);
      check_seq("sweep_seq", seq, n);
    end

    repeat (3) @(negedge clk);
    check("sb_empty", sb.size(), 0);
    check("done_count", n_done, n_push);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

// File: doc/sar_search.md
Name: sar_search

Overview:
- Successive-approximation search controller that drives a magnitude comparator and consumes its eq/lt/gt result to recover an unknown target value, MSB first.
- It is the initiator side of the comparator interface. It issues a registered trial value (guess) and samples the comparator's one-hot relation of target vs guess in the same cycle.
- Used in the lab datapath wherever a hidden WIDTH-bit operand must be resolved through compare-only access.

Parameters:
- WIDTH, 4, bit width of target, guess and result; WIDTH >= 2.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin a search; sampled only in IDLE.
- cmp_eq  input  1  comparator: target == guess.
- cmp_lt  input  1  comparator: target < guess.
- cmp_gt  input  1  comparator: target > guess.
- guess  output  WIDTH  trial value presented to the comparator (registered).
- busy  output  1  high while in SEARCH.
- done  output  1  one-cycle pulse when a search ends.
- result  output  WIDTH  recovered value; held from done until the next accepted start.
- hit  output  1  search ended on cmp_eq; held with result.
- err  output  1  comparator response was not one-hot; held with result.

Behaviour:
- Reset (async, rst_n=0): state=IDLE. guess=0, busy=0, done=0, result=0, hit=0, err=0, internal acc=0, bit index k=WIDTH-1.
- States are IDLE, SEARCH and DONE.
- IDLE, start=1:
  - acc<=0, k<=WIDTH-1.
  - guess<=1<<(WIDTH-1), busy<=1.
  - hit<=0, err<=0.
  - Next state SEARCH.
- IDLE, start=0: all outputs hold.
- SEARCH, each cycle: sample {cmp_eq,cmp_lt,cmp_gt} against the current guess.
  - Not exactly one flag high: err<=1, result<=acc, go to DONE.
  - cmp_eq: hit<=1, result<=guess, go to DONE (early exit).
  - cmp_gt: acc<=guess (keep bit k).
  - cmp_lt: acc unchanged (clear bit k).
  - If k>0 (and no exit): k<=k-1, guess<=newacc | (1<<(k-1)).
  - If k==0 (and no exit): result<=newacc, hit<=0, go to DONE.
- DONE: done=1 for exactly this one cycle, busy=0, guess holds, next state IDLE.
  - A start seen in DONE is ignored; start is accepted only in IDLE.
- Latency from the start-accept edge to done high:
  - 1+n cycles, where n is the number of SEARCH cycles.
  - n ranges from 1 (target equals the MSB weight) to WIDTH.
  - Shortest start-to-start turnaround is n+2 cycles.
- Width rules:
  - All arithmetic is WIDTH-bit unsigned, with no carry.
  - guess never exceeds 2^WIDTH-1.
  - The result is exact for every target 0..2^WIDTH-1.
  - Target 0 never produces cmp_eq, so it ends with hit=0.
- start while busy or done: ignored, with no effect on the search in progress.
- Reset mid-SEARCH: immediate return to IDLE with all outputs at their reset values, and no done pulse.
- The comparator path is combinational from guess to cmp_*. No extra cycle is inserted.

Decomposition:
- Shared package sar_pkg:
  - state typedef with encodings IDLE=2'b00, SEARCH=2'b01, DONE=2'b10.
  - localparam default WIDTH=4.
- No sub-module in the RTL; the FSM, acc and k live in one module.
- The bench pairs sar_search (WIDTH=4) with the team's existing 4-bit comparator. Target feeds x, guess feeds y, and eq/lt/gt map directly to cmp_eq/cmp_lt/cmp_gt.

Test Plan:
- Target 4'hB, pulse start:
  - guess sequence 8,C,A,B with responses gt,lt,gt,eq.
  - done 5 cycles after accept, result=B, hit=1, err=0.
- Target 4'h8: first guess 8 gives eq; done 2 cycles after accept, result=8, hit=1.
- Target 4'h0 and 4'hF:
  - 0: guesses 8,4,2,1 all lt, result=0, hit=0.
  - F: guesses 8,C,E,F, result=F, hit=1.
  - Exhaustive sweep 0..15: result==target for every value, done pulses exactly once per search.
- Fault injection, forcing cmp_eq=cmp_lt=1 on the second SEARCH cycle with target 4'hB: err=1, result=8, done pulses, next start clears err.
- start held high for 10 cycles with target 4'h5: only one search runs (no restart in SEARCH or DONE), result=5. A second search begins only after return to IDLE.
- rst_n low for half a cycle during the third SEARCH cycle: all outputs 0 asynchronously, no done pulse. A subsequent start with target 4'h3 completes normally with result=3.
